button_event_queue: RTL and testbench
=====================================

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 Parameter: NUM_BTN, 4, number of debounced button pulse inputs (2..8).
REQ-002 Parameter: DEPTH, 8, event FIFO depth in entries (power of two, 2..32).
REQ-003 Port: clk  input  1  system clock; all state updates on posedge.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: btn_pulse  input  NUM_BTN  one-cycle press/auto-repeat pulses from the per-button debouncers; bit i = button i.
REQ-006 Port: clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-007 Port: out_valid  output  1  FIFO head holds a valid event.
REQ-008 Port: out_btn  output  clog2(NUM_BTN)  button index of the head event; don't-care when out_valid=0.
REQ-009 Port: out_ready  input  1  consumer accepts the head event; pop when out_valid && out_ready.
REQ-010 Port: count  output  clog2(DEPTH)+1  number of entries stored in the FIFO.
REQ-011 Port: overflow  output  1  sticky; at least one event has been dropped since the last reset or clr_ovf.

Function
REQ-012 Each button SHALL have a pending bit, set on the clock edge after btn_pulse[i]=1.
REQ-013 The arbiter SHALL grant at most one pending button per cycle, and only when count < DEPTH, evaluated before the same-cycle pop (no full-FIFO bypass).
REQ-014 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NUM_BTN; last_grant resets to NUM_BTN-1, so index 0 wins first.
REQ-015 A granted button's index SHALL be written at the FIFO tail and its pending bit cleared on the same edge.
REQ-016 If btn_pulse[i]=1 in the same cycle pending[i] is granted, pending[i] SHALL remain set as a new event.
REQ-017 If btn_pulse[i]=1 while pending[i]=1 and i is not granted that cycle, the pulse SHALL be dropped and overflow set on the next edge.
REQ-018 Latency: a pulse in cycle N with an empty FIFO and no contention SHALL give out_valid=1 with out_btn=i in cycle N+2.
REQ-019 The FIFO SHALL be first-word-fall-through: out_btn is valid combinationally whenever out_valid=1, and out_valid = (count != 0).
REQ-020 Simultaneous push and pop SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-021 Pop when empty SHALL be ignored; count never underflows or exceeds DEPTH.
REQ-022 clr_ovf=1 SHALL clear overflow on the next edge unless a drop occurs in the same cycle, in which case overflow stays set (set wins).
REQ-023 Event order at the output SHALL equal grant order.

Reset
REQ-024 While reset_n=0: pending=0, last_grant=NUM_BTN-1, pointers=0, count=0, out_valid=0, overflow=0.
REQ-025 Reset assertion mid-operation SHALL discard all pending and queued events immediately; FIFO storage contents need not be cleared.
REQ-026 The first edge after reset_n deasserts SHALL sample btn_pulse normally.

Structure
REQ-027 The shared package SHALL hold the default NUM_BTN and DEPTH values and the button-index width function/constant used by this block and its consumers.
REQ-028 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH; push/full, pop/empty, count), instantiated once; the pending bits and arbiter stay in button_event_queue.

Verification
REQ-029 Single press: btn_pulse=4'b0100 for one cycle N, out_ready=1 -> out_valid=1, out_btn=2 in cycle N+2 only; count returns to 0.
REQ-030 Simultaneous: btn_pulse=4'b1111 for one cycle, out_ready=1 -> events 0,1,2,3 on consecutive cycles; then btn_pulse=4'b1001 -> order 0,3.
REQ-031 Fill: out_ready=0, 8 separated pulses on button 1 -> count=8; a 9th pulse stays pending; a 10th pulse on button 1 -> overflow=1; raising out_ready yields 9 events total.
REQ-032 Regrant race: pending[3] granted in the same cycle as a new btn_pulse[3] -> two button-3 events queued, overflow=0.
REQ-033 Overflow clear: overflow=1, clr_ovf pulsed with no drop -> overflow=0; clr_ovf concurrent with a drop -> overflow stays 1.
REQ-034 Async reset: reset_n low with count=5 and pending=4'b0011 -> out_valid=0, count=0 without a clock edge; after release, a pulse on button 0 -> out_btn=0 after 2 cycles.

Source files
------------

// File: rtl/button_event_queue_pkg.sv
// Shared defaults and index-width helper for the button event queue and its consumers.
package button_event_queue_pkg;

    localparam int DEF_NUM_BTN = 4;
    localparam int DEF_DEPTH   = 8;

    // Width of a button index; never narrower than one bit.
    function automatic int btn_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; push is refused when full, pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uninitialised; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/button_event_queue.sv
// Latches button pulses as pending events and round-robin arbitrates them into an event FIFO.
module button_event_queue
    import button_event_queue_pkg::*;
#(
    parameter int NUM_BTN = DEF_NUM_BTN,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_BTN-1:0]             btn_pulse,
    input  logic                           clr_ovf,
    output logic                           out_valid,
    output logic [btn_idx_w(NUM_BTN)-1:0]  out_btn,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow
);

    localparam int BW = btn_idx_w(NUM_BTN);

    logic [NUM_BTN-1:0] pending_q, pending_d, grant_oh;
    logic [BW-1:0]      last_grant_q, last_grant_d, grant_idx;
    logic [BW:0]        sum;
    logic               overflow_q, overflow_d;
    logic               found, grant_en, drop, fifo_full, fifo_empty;

    // Search from last_grant+1 upward, wrapping at NUM_BTN (need not be a power of two).
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            sum = {1'b0, last_grant_q} + (BW+1)'(k);
            if (sum >= (BW+1)'(NUM_BTN)) sum = sum - (BW+1)'(NUM_BTN);
            if (!found && pending_q[sum[BW-1:0]]) begin
                found     = 1'b1;
                grant_idx = sum[BW-1:0];
            end
        end
    end

    // A pulse on a just-granted button re-arms it; on a still-waiting one it is lost.
    always_comb begin
        grant_en     = found && !fifo_full;
        grant_oh     = grant_en ? (NUM_BTN'(1) << grant_idx) : '0;
        drop         = |(btn_pulse & pending_q & ~grant_oh);
        pending_d    = (pending_q & ~grant_oh) | btn_pulse;
        overflow_d   = drop | (overflow_q & ~clr_ovf);
        last_grant_d = grant_en ? grant_idx : last_grant_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= '0;
            last_grant_q <= BW'(NUM_BTN - 1);
            overflow_q   <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (grant_en),
        .wdata   (grant_idx),
        .full    (fifo_full),
        .pop     (out_ready),
        .rdata   (out_btn),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Randomised and directed checks of button_event_queue against a queue-based reference model.
module tb_button_event_queue;

    localparam int NUM_BTN = 4;
    localparam int DEPTH   = 8;
    localparam int BW      = $clog2(NUM_BTN);

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NUM_BTN-1:0]     btn_pulse = '0;
    logic                   clr_ovf = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [BW-1:0]          out_btn;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    // reference model state
    bit mpend [NUM_BTN];
    int mlast;
    int mq [$];
    bit movf;

    button_event_queue #(.NUM_BTN(NUM_BTN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_pulse (btn_pulse),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_btn   (out_btn),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mpend[i]) mpend[i] = 1'b0;
        mlast = NUM_BTN - 1;
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic model_edge(input logic [NUM_BTN-1:0] p, input bit clr, input bit rdy);
        int  g = -1;
        bit  drop = 1'b0;
        bit  do_pop = rdy && (mq.size() > 0);
        if (mq.size() < DEPTH)
            for (int k = 1; k <= NUM_BTN; k++)
                if (g < 0 && mpend[(mlast + k) % NUM_BTN]) g = (mlast + k) % NUM_BTN;
        if (do_pop) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back(g);
            mpend[g] = 1'b0;
            mlast = g;
        end
        for (int i = 0; i < NUM_BTN; i++)
            if (p[i]) begin
                if (mpend[i]) drop = 1'b1;
                else mpend[i] = 1'b1;
            end
        movf = drop ? 1'b1 : (clr ? 1'b0 : movf);
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_btn", 32'(out_btn), 32'(mq[0]));
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    // One clock cycle: drive just after the edge, compare on the falling edge, advance the model on the rising edge.
    task automatic step(input logic [NUM_BTN-1:0] p, input bit clr, input bit rdy);
        #1;
        btn_pulse = p;
        clr_ovf   = clr;
        out_ready = rdy;
        @(negedge clk);
        check_outputs();
        if (rdy && out_valid) pops++;
        @(posedge clk);
        model_edge(p, clr, rdy);
    endtask

    task automatic async_reset();
        #2;
        btn_pulse = '0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [NUM_BTN-1:0] p;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_count", 32'(count), 32'd0);
        chk("init_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);

        // single press, two-cycle latency
        step(4'b0100, 0, 1);
        step(4'b0000, 0, 1);
        #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_btn", 32'(out_btn), 32'd2);
        repeat (3) step('0, 0, 1);

        // simultaneous presses
        step(4'b1111, 0, 1);
        repeat (6) step('0, 0, 1);
        step(4'b1001, 0, 1);
        repeat (4) step('0, 0, 1);

        // fill, then pile up pending and drop
        for (int n = 0; n < 8; n++) begin
            step(4'b0010, 0, 0);
            step(4'b0000, 0, 0);
        end
        #1;
        chk("fill_count", 32'(count), 32'd8);
        step(4'b0010, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b0010, 0, 0);
        #1;
        chk("fill_ovf", 32'(overflow), 32'd1);
        step('0, 1, 0);
        #1;
        chk("clr_ovf", 32'(overflow), 32'd0);
        step(4'b0010, 1, 0);
        #1;
        chk("clr_vs_drop", 32'(overflow), 32'd1);
        step('0, 1, 0);
        pops = 0;
        repeat (14) step('0, 0, 1);
        chk("fill_pops", 32'(pops), 32'd9);

        // regrant race on button 3
        step(4'b1000, 0, 0);
        step(4'b1000, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b0000, 0, 0);
        #1;
        chk("race_count", 32'(count), 32'd2);
        chk("race_ovf", 32'(overflow), 32'd0);
        repeat (4) step('0, 0, 1);

        // async reset with queued and pending events
        for (int n = 0; n < 5; n++) begin
            step(NUM_BTN'(1) << (n % NUM_BTN), 0, 0);
            step('0, 0, 0);
        end
        step(4'b0011, 0, 0);
        #1;
        chk("pre_rst_count", 32'(count), 32'd5);
        async_reset();
        step(4'b0001, 0, 1);
        step(4'b0000, 0, 1);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_btn", 32'(out_btn), 32'd0);
        step('0, 0, 1);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NUM_BTN; i++) p[i] = ($urandom_range(0, 3) == 0);
            step(p, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end
        repeat (12) step('0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
